// File: rtl/bss_pkg.sv
// Shared types and constants for the Basys3 seven-segment scan controller.
package bss_pkg;

    typedef enum logic {ST_DRIVE, ST_GUARD} bss_scan_state_e;

    localparam int unsigned BSS_MAX_DIGITS = 16;

    localparam logic [6:0]                BSS_BLANK_CATHODE = 7'h7F;
    localparam logic [BSS_MAX_DIGITS-1:0] BSS_ANODE_OFF     = '1;

    function automatic int unsigned bss_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bss_decoder.sv
// Hex nibble to active-low seven-segment cathode pattern {g,f,e,d,c,b,a}.
module bss_decoder (
    input  logic [3:0] nibble_i,
    output logic [6:0] cathode_c_o
);

    always_comb begin
        cathode_c_o = 7'h7F;
        case (nibble_i)
            4'h0: cathode_c_o = 7'b1000000;
            4'h1: cathode_c_o = 7'b1111001;
            4'h2: cathode_c_o = 7'b0100100;
            4'h3: cathode_c_o = 7'b0110000;
            4'h4: cathode_c_o = 7'b0011001;
            4'h5: cathode_c_o = 7'b0010010;
            4'h6: cathode_c_o = 7'b0000010;
            4'h7: cathode_c_o = 7'b1111000;
            4'h8: cathode_c_o = 7'b0000000;
            4'h9: cathode_c_o = 7'b0010000;
            4'hA: cathode_c_o = 7'b0001000;
            4'hB: cathode_c_o = 7'b0000011;
            4'hC: cathode_c_o = 7'b1000110;
            4'hD: cathode_c_o = 7'b0100001;
            4'hE: cathode_c_o = 7'b0000110;
            4'hF: cathode_c_o = 7'b0001110;
            default: cathode_c_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/bss_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Optional leading-zero suppression is enabled by defining BSS_LZ_SUPPRESS_EN.
module bss_scan_ctrl
    import bss_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned GUARD_CYCLES = 2000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic                    load_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    output logic [NUM_DIGITS-1:0]   anode_o,
    output logic [6:0]              cathode_bits_o,
    output logic                    dp_o,
    output logic                    frame_o
);

    localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W      = $clog2(bss_max(DIGIT_CYCLES, GUARD_CYCLES) + 1);
    localparam int unsigned GUARD_LAST = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;

    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      CNT_DRIVE = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_GUARD = CNT_W'(GUARD_LAST);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = BSS_ANODE_OFF[NUM_DIGITS-1:0];

    bss_scan_state_e             state_q;
    logic [IDX_W-1:0]            idx_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        boot_q;

    logic [NUM_DIGITS-1:0][3:0]  shd_val_q;
    logic [NUM_DIGITS-1:0]       shd_en_q;
    logic [NUM_DIGITS-1:0]       shd_dp_q;
    logic [NUM_DIGITS-1:0][3:0]  disp_val_q;
    logic [NUM_DIGITS-1:0]       disp_en_q;
    logic [NUM_DIGITS-1:0]       disp_dp_q;

    logic [NUM_DIGITS-1:0]       anode_q;
    logic [6:0]                  cathode_q;
    logic                        dp_q;
    logic                        frame_q;

    logic                        drive_done_c;
    logic                        guard_done_c;
    logic                        enter_drive_c;
    logic [IDX_W-1:0]            idx_next_c;
    logic [IDX_W-1:0]            enter_idx_c;
    logic [NUM_DIGITS-1:0]       lit_en_c;
    logic [6:0]                  dec_c;

    logic [NUM_DIGITS-1:0]       anode_d;
    logic [6:0]                  cathode_d;
    logic                        dp_d;

    // Slot sequencing: the boot guard after reset leads into digit 0, not idx+1.
    always_comb begin
        drive_done_c  = (cnt_q == CNT_DRIVE);
        guard_done_c  = (GUARD_CYCLES == 0) || (cnt_q == CNT_GUARD);
        idx_next_c    = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        enter_idx_c   = boot_q ? '0 : idx_next_c;
        enter_drive_c = (state_q == ST_GUARD) ? guard_done_c
                                              : (drive_done_c && (GUARD_CYCLES == 0));
    end

`ifdef BSS_LZ_SUPPRESS_EN
    logic [NUM_DIGITS-1:0] lz_blank_c;
    logic                  lz_zero_c;

    // A digit is blanked when it and every more-significant nibble are zero; digit 0 never is.
    always_comb begin
        lz_blank_c = '0;
        lz_zero_c  = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            lz_zero_c     = lz_zero_c && (disp_val_q[k] == 4'h0);
            lz_blank_c[k] = lz_zero_c;
        end
        lit_en_c = disp_en_q & ~lz_blank_c;
    end
`else
    assign lit_en_c = disp_en_q;
`endif

    bss_decoder u_decoder (
        .nibble_i    (disp_val_q[idx_q]),
        .cathode_c_o (dec_c)
    );

    always_comb begin
        anode_d   = ANODE_OFF;
        cathode_d = BSS_BLANK_CATHODE;
        dp_d      = 1'b1;
        if (state_q == ST_DRIVE) begin
            if (lit_en_c[idx_q]) begin
                anode_d[idx_q] = 1'b0;
            end
            cathode_d = dec_c;
            dp_d      = ~disp_dp_q[idx_q];
        end
    end

    // Scan FSM, shadow/display registers and registered pin drivers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_GUARD;
            idx_q      <= '0;
            cnt_q      <= '0;
            boot_q     <= 1'b1;
            shd_val_q  <= '0;
            shd_en_q   <= '0;
            shd_dp_q   <= '0;
            disp_val_q <= '0;
            disp_en_q  <= '0;
            disp_dp_q  <= '0;
            anode_q    <= ANODE_OFF;
            cathode_q  <= BSS_BLANK_CATHODE;
            dp_q       <= 1'b1;
            frame_q    <= 1'b0;
        end else begin
            if (load_i) begin
                shd_val_q <= value_i;
                shd_en_q  <= digit_en_i;
                shd_dp_q  <= dp_i;
            end

            frame_q <= 1'b0;
            if (enter_drive_c) begin
                state_q <= ST_DRIVE;
                idx_q   <= enter_idx_c;
                cnt_q   <= '0;
                boot_q  <= 1'b0;
                frame_q <= !boot_q && (idx_q == IDX_LAST);
                if (enter_idx_c == '0) begin
                    disp_val_q <= shd_val_q;
                    disp_en_q  <= shd_en_q;
                    disp_dp_q  <= shd_dp_q;
                end
            end else if ((state_q == ST_DRIVE) && drive_done_c) begin
                state_q <= ST_GUARD;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            anode_q   <= anode_d;
            cathode_q <= cathode_d;
            dp_q      <= dp_d;
        end
    end

    assign anode_o        = anode_q;
    assign cathode_bits_o = cathode_q;
    assign dp_o           = dp_q;
    assign frame_o        = frame_q;

endmodule
